// File: rtl/mistral_lut_mask_loader.sv
// Bit-serial LUT mask loader: shifts in framed masks, checks even parity per frame,
// and commits each good frame to the LUT mask bus in a single cycle.
module mistral_lut_mask_loader #(
    parameter int NUM_LUTS  = 4,
    parameter int LUT_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          sclr,
    input  logic                          start,
    input  logic                          din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [NUM_LUTS*LUT_WIDTH-1:0] lut_masks
);

    localparam int CNT_W = $clog2(LUT_WIDTH + 1);
    localparam int IDX_W = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        COMMIT
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [LUT_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]     count;
    logic                 parity;
    logic [IDX_W-1:0]     frame_idx;
    logic                 accept;
    logic                 last_bit;
    logic                 last_frame;
    logic                 parity_bad;

    assign accept     = din_valid & din_ready;
    assign last_bit   = (count == CNT_W'(LUT_WIDTH - 1));
    assign last_frame = (frame_idx == IDX_W'(NUM_LUTS - 1));
    assign parity_bad = parity ^ din;

    always_ff @(posedge clk) begin
        if (sclr) begin
            state     <= IDLE;
            shreg     <= '0;
            count     <= '0;
            parity    <= 1'b0;
            frame_idx <= '0;
            lut_masks <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        done      <= 1'b0;
                        err       <= 1'b0;
                        count     <= '0;
                        parity    <= 1'b0;
                        frame_idx <= '0;
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        shreg  <= {din, shreg[LUT_WIDTH-1:1]};
                        parity <= parity ^ din;
                        count  <= count + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (accept && parity_bad) begin
                        err <= 1'b1;
                    end
                end
                COMMIT: begin
                    // Whole-frame write so the LUTs never observe a half-shifted mask.
                    lut_masks[frame_idx*LUT_WIDTH +: LUT_WIDTH] <= shreg;
                    count  <= '0;
                    parity <= 1'b0;
                    if (last_frame) begin
                        done <= 1'b1;
                    end else begin
                        frame_idx <= frame_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        din_ready  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                din_ready = 1'b1;
                if (din_valid && last_bit) begin
                    state_next = PARITY;
                end
            end
            PARITY: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    state_next = parity_bad ? IDLE : COMMIT;
                end
            end
            COMMIT: begin
                state_next = last_frame ? IDLE : SHIFT;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mistral_lut_mask_loader.sv
// Directed bench for mistral_lut_mask_loader: a scoreboard queue holds the mask bus
// expected after each commit and is drained whenever the bus changes.
module tb_mistral_lut_mask_loader;

    logic         clk = 1'b0;
    logic         sclr, start, din, din_valid;
    logic         din_ready, busy, done, err;
    logic [255:0] lut_masks;

    logic         nSclr, nStart, nDin, nDinValid;
    logic         nDinReady, nBusy, nDone, nErr;
    logic [7:0]   nLutMasks;

    int           checks = 0;
    int           failures = 0;
    logic [255:0] expQ[$];
    logic [255:0] model;
    logic [255:0] lastMasks;
    logic [63:0]  basic [4];
    logic [63:0]  errFrames [4];
    logic [7:0]   nVal;
    int           de;

    always #5 clk = ~clk;

    mistral_lut_mask_loader #(.NUM_LUTS(4), .LUT_WIDTH(64)) dut (
        .clk(clk), .sclr(sclr), .start(start), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .busy(busy), .done(done), .err(err), .lut_masks(lut_masks)
    );

    mistral_lut_mask_loader #(.NUM_LUTS(1), .LUT_WIDTH(8)) dutNarrow (
        .clk(clk), .sclr(nSclr), .start(nStart), .din(nDin), .din_valid(nDinValid),
        .din_ready(nDinReady), .busy(nBusy), .done(nDone), .err(nErr), .lut_masks(nLutMasks)
    );

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        sclr = 1'b1;
        @(posedge clk);
        #1 sclr = 1'b0;
        model = '0;
        lastMasks = '0;
        expQ.delete();
    endtask

    // START is sampled on the following rising edge, which is edge 0.
    task automatic startSeq();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Streams nFrames frames (data LSB first, then even parity bit); badFrame gets a flipped
    // parity bit, abortAt pulses sclr once that many bits are accepted, startAt re-asserts start.
    task automatic applyStimulus(input logic [63:0] frames [4], input int nFrames, input int badFrame,
                                 input bit toggle, input int abortAt, input int startAt,
                                 output int doneEdge);
        logic bits[$];
        int   idx = 0;
        int   edges = 0;
        bit   phase = 1'b1;
        bit   commitNext = 1'b0;
        bit   acc;
        bit   finished = 1'b0;
        for (int f = 0; f < nFrames; f++) begin
            for (int b = 0; b < 64; b++) bits.push_back(frames[f][b]);
            bits.push_back((^frames[f]) ^ (f == badFrame));
            if (f != badFrame) begin
                model[f*64 +: 64] = frames[f];
                expQ.push_back(model);
            end
        end
        doneEdge = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (commitNext) begin
                checkOutput("ready_in_commit", {255'b0, din_ready}, 256'd0);
                commitNext = 1'b0;
            end
            if (lut_masks !== lastMasks) begin
                if (expQ.size() == 0) checkOutput("unexpected_commit", lut_masks, lastMasks);
                else checkOutput("commit_masks", lut_masks, expQ.pop_front());
                lastMasks = lut_masks;
            end
            if (idx >= bits.size() && (done || err)) begin
                doneEdge = edges;
                finished = 1'b1;
                break;
            end
            if (abortAt >= 0 && idx == abortAt) begin
                sclr = 1'b1;
                din_valid = 1'b0;
                @(posedge clk);
                #1 sclr = 1'b0;
                finished = 1'b1;
                break;
            end
            start = (idx == startAt);
            din_valid = toggle ? phase : 1'b1;
            phase = ~phase;
            if (idx < bits.size()) din = bits[idx];
            else din_valid = 1'b0;
            acc = din_valid && din_ready;
            @(posedge clk);
            edges++;
            #1 start = 1'b0;
            if (acc) begin
                if (idx % 65 == 64 && idx / 65 != badFrame) commitNext = 1'b1;
                idx++;
            end
        end
        din_valid = 1'b0;
        checkOutput("stream_completed", {255'b0, finished}, 256'd1);
    endtask

    initial begin
        sclr = 1'b1; start = 1'b0; din = 1'b0; din_valid = 1'b0;
        nSclr = 1'b1; nStart = 1'b0; nDin = 1'b0; nDinValid = 1'b0;
        basic[0] = 64'h0000_0000_0000_0001;
        basic[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        basic[2] = 64'h8000_0000_0000_0000;
        basic[3] = 64'h6996_9669_9669_6996;
        errFrames[0] = 64'hDEAD_BEEF_0123_4567;
        errFrames[1] = 64'h0000_0000_0000_0001;
        errFrames[2] = 64'h0;
        errFrames[3] = 64'h0;
        model = '0;
        lastMasks = '0;
        repeat (2) @(posedge clk);
        #1 sclr = 1'b0;
        nSclr = 1'b0;

        @(negedge clk);
        checkOutput("reset_masks", lut_masks, 256'd0);
        checkOutput("reset_busy", {255'b0, busy}, 256'd0);
        checkOutput("reset_ready", {255'b0, din_ready}, 256'd0);
        checkOutput("reset_done", {255'b0, done}, 256'd0);
        checkOutput("reset_err", {255'b0, err}, 256'd0);

        $display("[TB] basic load");
        startSeq();
        applyStimulus(basic, 4, -1, 1'b0, -1, -1, de);
        checkOutput("basic_done_edge", 256'(de), 256'd264);
        checkOutput("basic_masks", lut_masks, {basic[3], basic[2], basic[1], basic[0]});
        checkOutput("basic_done", {255'b0, done}, 256'd1);
        checkOutput("basic_err", {255'b0, err}, 256'd0);
        checkOutput("basic_busy", {255'b0, busy}, 256'd0);
        checkOutput("idle_ready", {255'b0, din_ready}, 256'd0);
        checkOutput("basic_queue_empty", 256'(expQ.size()), 256'd0);

        $display("[TB] parity error");
        startSeq();
        applyStimulus(errFrames, 2, 1, 1'b0, -1, -1, de);
        checkOutput("perr_err_edge", 256'(de), 256'd131);
        checkOutput("perr_err", {255'b0, err}, 256'd1);
        checkOutput("perr_done", {255'b0, done}, 256'd0);
        checkOutput("perr_masks", lut_masks, {basic[3], basic[2], basic[1], errFrames[0]});
        checkOutput("perr_busy", {255'b0, busy}, 256'd0);
        checkOutput("perr_queue_empty", 256'(expQ.size()), 256'd0);

        $display("[TB] stalled load");
        doReset();
        @(negedge clk);
        checkOutput("sclr_clears_masks", lut_masks, 256'd0);
        checkOutput("sclr_clears_err", {255'b0, err}, 256'd0);
        startSeq();
        applyStimulus(basic, 4, -1, 1'b1, -1, -1, de);
        checkOutput("stall_masks", lut_masks, {basic[3], basic[2], basic[1], basic[0]});
        checkOutput("stall_done", {255'b0, done}, 256'd1);
        checkOutput("stall_slower", {255'b0, (de > 264 && de <= 527)}, 256'd1);
        checkOutput("stall_queue_empty", 256'(expQ.size()), 256'd0);

        $display("[TB] reset mid-frame");
        doReset();
        startSeq();
        applyStimulus(basic, 4, -1, 1'b0, 160, -1, de);
        @(negedge clk);
        checkOutput("abort_masks", lut_masks, 256'd0);
        checkOutput("abort_busy", {255'b0, busy}, 256'd0);
        checkOutput("abort_done", {255'b0, done}, 256'd0);
        checkOutput("abort_err", {255'b0, err}, 256'd0);
        model = '0;
        lastMasks = '0;
        expQ.delete();
        startSeq();
        applyStimulus(basic, 4, -1, 1'b0, -1, -1, de);
        checkOutput("reload_done_edge", 256'(de), 256'd264);
        checkOutput("reload_masks", lut_masks, {basic[3], basic[2], basic[1], basic[0]});

        $display("[TB] start while busy");
        doReset();
        startSeq();
        applyStimulus(basic, 4, -1, 1'b0, -1, 100, de);
        checkOutput("rebusy_done_edge", 256'(de), 256'd264);
        checkOutput("rebusy_masks", lut_masks, {basic[3], basic[2], basic[1], basic[0]});
        checkOutput("rebusy_done", {255'b0, done}, 256'd1);

        $display("[TB] sclr with start");
        @(negedge clk);
        sclr = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 sclr = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("sclr_start_busy", {255'b0, busy}, 256'd0);
        checkOutput("sclr_start_ready", {255'b0, din_ready}, 256'd0);
        checkOutput("sclr_start_masks", lut_masks, 256'd0);
        @(negedge clk);
        checkOutput("sclr_start_busy_later", {255'b0, busy}, 256'd0);

        $display("[TB] narrow lut");
        nVal = 8'h96;
        @(negedge clk);
        nStart = 1'b1;
        @(posedge clk);
        #1 nStart = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            nDin = (i < 8) ? nVal[i] : 1'b0;
            nDinValid = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        nDinValid = 1'b0;
        checkOutput("narrow_done_early", {255'b0, nDone}, 256'd0);
        checkOutput("narrow_ready_commit", {255'b0, nDinReady}, 256'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("narrow_done", {255'b0, nDone}, 256'd1);
        checkOutput("narrow_masks", {248'b0, nLutMasks}, 256'h96);
        checkOutput("narrow_err", {255'b0, nErr}, 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
